// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the iterative divider.
interface div_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      div_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, div_op, op1, op2, flush, input busy, done, result);
    modport slave (input start, div_op, op1, op2, flush, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit #(parameter int XLEN = 32) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          r_state, w_next, w_enter;
    logic [5:0]      r_cnt;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_dvd, r_dvs, r_result, r_spec_val;
    logic [XLEN:0]   r_rem;
    logic            r_neg_q, r_neg_r, r_spec;
    logic            w_signed, w_dz, w_ovf, w_spec_in, w_accept, w_early, w_ge;
    logic [XLEN-1:0] w_spec_val_in, w_abs1, w_abs2, w_q_nx, w_q_fin, w_r_fin, w_calc_res;
    logic [XLEN+1:0] w_sh, w_diff;
    logic [XLEN:0]   w_rem_nx;
    assign w_signed      = ~bus.div_op[0];
    assign w_dz          = bus.op2 == '0;
    assign w_ovf         = w_signed && bus.op1 == 32'h8000_0000 && bus.op2 == '1;
    assign w_spec_in     = w_dz | w_ovf;
    assign w_spec_val_in = w_dz ? (bus.div_op[1] ? bus.op1 : '1) : (bus.div_op[1] ? '0 : 32'h8000_0000);
    assign w_accept      = bus.start && !bus.flush && (r_state == IDLE || r_state == DONE);
    assign w_abs1        = (w_signed && bus.op1[XLEN-1]) ? -bus.op1 : bus.op1;
    assign w_abs2        = (w_signed && bus.op2[XLEN-1]) ? -bus.op2 : bus.op2;
`ifdef DIV_EARLY_OUT_EN
    assign w_early = w_spec_in;
`else
    assign w_early = 1'b0;
`endif
    // r_rem stays below the divisor, so its top bit is always clear; the extra bit keeps the trial sign
    assign w_sh       = {r_rem, r_dvd[XLEN-1]};
    assign w_diff     = w_sh - {2'b00, r_dvs};
    assign w_ge       = ~w_diff[XLEN+1];
    assign w_rem_nx   = w_ge ? w_diff[XLEN:0] : w_sh[XLEN:0];
    assign w_q_nx     = {r_dvd[XLEN-2:0], w_ge};
    assign w_q_fin    = r_neg_q ? -w_q_nx : w_q_nx;
    assign w_r_fin    = r_neg_r ? -w_rem_nx[XLEN-1:0] : w_rem_nx[XLEN-1:0];
    assign w_calc_res = r_spec ? r_spec_val : (r_op[1] ? w_r_fin : w_q_fin);
    assign w_enter    = w_early ? DONE : CALC;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = bus.flush ? IDLE : (r_state == CALC) ? (r_cnt == 6'd0 ? DONE : CALC) : w_accept ? w_enter : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_result   <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= 6'd31;
                r_op       <= bus.div_op;
                r_dvd      <= w_abs1;
                r_dvs      <= w_abs2;
                r_rem      <= '0;
                r_neg_q    <= w_signed & (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
                r_neg_r    <= w_signed & bus.op1[XLEN-1];
                r_spec     <= w_spec_in;
                r_spec_val <= w_spec_val_in;
            end else if (r_state == CALC) begin
                r_rem <= w_rem_nx;
                r_dvd <= w_q_nx;
                if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
            end
            if (w_next == DONE) r_result <= (r_state == CALC) ? w_calc_res : w_spec_val_in;
        end
    end
    always_comb begin
        bus.busy   = r_state == CALC;
        bus.done   = r_state == DONE;
        bus.result = r_result;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: random and directed checks of div_unit against an arithmetic reference.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] r_last = '0;
    div_unit_if bus();
    div_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic bit special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction
    function automatic int lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        return special(op, a, b) ? 1 : 33;
`else
        return (special(op, a, b) && 1'b0) ? 1 : 33;
`endif
    endfunction
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int ign);
        logic [31:0] exp;
        int n;
        exp = ref_res(op, a, b);
        n = lat(op, a, b);
        bus.div_op = op;
        bus.op1 = a;
        bus.op2 = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < n; c++) begin
            chk("busy", {31'b0, bus.busy}, 32'd1);
            chk("early_done", {31'b0, bus.done}, 32'd0);
            chk("hold", bus.result, r_last);
            if (c == ign) begin
                bus.start = 1'b1;
                bus.op1 = ~a;
                bus.op2 = 32'd5;
            end
            step();
            bus.start = 1'b0;
        end
        chk("done", {31'b0, bus.done}, 32'd1);
        chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
        chk("result", bus.result, exp);
        r_last = exp;
    endtask
    task automatic idle_check();
        step();
        chk("done_pulse", {31'b0, bus.done}, 32'd0);
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);
        chk("result_keep", bus.result, r_last);
    endtask
    initial begin
        logic [1:0] op;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.div_op = 2'b00;
        bus.op1 = '0;
        bus.op2 = '0;
        step();
        step();
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        reset = 1'b0;
        step();
        run_op(2'b01, 32'd100, 32'd7, -1); idle_check();
        run_op(2'b11, 32'd100, 32'd7, -1); idle_check();
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, -1); idle_check();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1); idle_check();
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, -1); idle_check();
        run_op(2'b01, 32'd5, 32'd0, -1); idle_check();
        run_op(2'b11, 32'd5, 32'd0, -1); idle_check();
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1); idle_check();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1); idle_check();
        run_op(2'b00, 32'hFFFF_FFF9, 32'd0, -1); idle_check();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1); idle_check();
        run_op(2'b01, 32'd9, 32'd3, 10);
        run_op(2'b11, 32'd9, 32'd4, -1);
        idle_check();
        bus.div_op = 2'b01;
        bus.op1 = 32'd100;
        bus.op2 = 32'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        for (int c = 16; c < 40; c++) begin
            chk("flush_done", {31'b0, bus.done}, 32'd0);
            chk("flush_result", bus.result, r_last);
            step();
        end
        bus.start = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("fs_busy", {31'b0, bus.busy}, 32'd0);
        chk("fs_done", {31'b0, bus.done}, 32'd0);
        step();
        chk("fs_busy2", {31'b0, bus.busy}, 32'd0);
        chk("fs_done2", {31'b0, bus.done}, 32'd0);
        chk("fs_result", bus.result, r_last);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_result", bus.result, 32'd0);
        r_last = '0;
        step();
        #2 reset = 1'b0;
        step();
        run_op(2'b01, 32'd100, 32'd7, -1); idle_check();
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(op, a, b, -1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
